rv_fdivsqrt: RTL and testbench
==============================

// Module: rv_fdivsqrt
// PURPOSE
//  Iterative IEEE-754 divide/square-root unit for the rv_core FPU (zfinx, integer regfile operands).
//  Generalised in format (EXPW/MANW) and quotient bits per cycle (QPC); adds FSQRT, RNE rounding,
//  fflags and asynchronous reset. Accepts one op per start; fixed latency; sits beside the 1/2-cycle FPU ops.
// PARAMETERS
//  EXPW    8   exponent width; bias B = 2**(EXPW-1)-1
//  MANW    23  stored mantissa width; FW = 1+EXPW+MANW
//  QPC     2   quotient/root bits retired per ITER cycle, one of {1,2,4}
//  SQRTEN  1   0: op=1 returns canonical NaN with NV; sqrt datapath removed
// PORTS
//  clk     in   1      clock
//  xreset  in   1      reset, asynchronous, active-low
//  rdy     in   1      pipeline enable; 0 freezes every register (state, counters, outputs)
//  start   in   1      launch request, sampled only when rdy=1 and busy=0
//  op      in   1      0: FDIV rs1/rs2, 1: FSQRT rs1 (rs2 ignored)
//  rs1     in   FW     dividend / radicand
//  rs2     in   FW     divisor
//  busy    out  1      1 from the launch edge until the edge that raises cmpl
//  cmpl    out  1      1-cycle pulse (rdy-qualified): result/fflags valid
//  result  out  FW     rounded result; held until next cmpl
//  fflags  out  5      {NV,DZ,OF,UF,NX}; held with result
// BEHAVIOUR
//  Reset (async, xreset=0): state IDLE, busy=0, cmpl=0, result=0, fflags=0, counters/datapath 0.
//  Mid-operation reset aborts the op with no cmpl. Deassertion takes effect on the next clk edge.
//  FSM (advances only when rdy=1): IDLE -> PREP -> ITER (N cycles) -> ROUND -> IDLE.
//   IDLE : start=1 latches op/rs1/rs2, busy<=1, cmpl<=0.
//   PREP : unpack, classify (zero/inf/NaN/sNaN); subnormal inputs flushed to signed zero.
//          Div: exp = e1-e2+B (EXPW+2-bit signed), sign = s1^s2.
//          Sqrt: odd unbiased exponent -> sig<<1; exp = ((e1-B)>>>1)+B.
//   ITER : restoring digit recurrence, QPC bits/cycle; N = ceil((MANW+3)/QPC) (default 13).
//          Down-counter loads N-1 in PREP, exits at 0. Final remainder != 0 -> sticky.
//   ROUND: normalise (div quotient in [0.5,2): shift, exp-1 if MSB=0); round-to-nearest-even
//          on guard/round/sticky; mantissa carry-out increments exp. Drives result, fflags,
//          cmpl<=1, busy<=0 on the same edge.
//  Latency: cmpl is high in cycle N+3 after the launch cycle (default 16) when rdy stays 1.
//  Throughput: next start is accepted in the cmpl cycle.
//  Fixed latency: special cases take the full N+3 cycles.
//  start while busy=1 is ignored; no queueing.
//  rdy=0 during cmpl holds cmpl=1 until the next rdy=1 cycle, then clears.
//  Exponent range: biased exp >= 2**EXPW-1 after rounding -> +/-inf, OF|NX.
//   exp <= 0 -> signed zero, UF|NX (no subnormal outputs). Any discarded bits -> NX.
//  Specials (priority top-down):
//   any sNaN -> qNaN, NV
//   any NaN -> qNaN
//   0/0, inf/inf, sqrt(x<0, x!=-0) -> qNaN, NV
//   x/0 (x finite nonzero) -> signed inf, DZ
//   inf/x -> signed inf
//   0/x, x/inf -> signed zero
//   sqrt(+/-0) -> +/-0
//   sqrt(+inf) -> +inf
//  Canonical qNaN: sign 0, exp all ones, mantissa MSB 1, rest 0 (0x7FC00000 default).
// TESTING (default params, rdy=1 unless stated)
//  div 0x40C00000/0x40000000 (6/2) -> 0x40400000, fflags=0, cmpl in cycle 16, busy 15 cycles
//  div 0x3F800000/0x40400000 (1/3) -> 0x3EAAAAAB, NX; sqrt 0x40000000 -> 0x3FB504F3, NX
//  div 0x3F800000/0x00000000 -> 0x7F800000, DZ; sqrt 0xC0800000 -> 0x7FC00000, NV
//  div 0x7F000000/0x3E800000 -> 0x7F800000, OF|NX
//  div 0x00800000/0x40000000 -> 0x00000000, UF|NX
//  rdy=0 for 5 cycles mid-ITER -> cmpl delayed exactly 5 cycles, same result
//  xreset pulse mid-ITER -> no cmpl; busy=0, result=0; new start completes normally
//  QPC=1 and QPC=4 builds -> identical results; latency = N+3 with N = 26 and 7

Source files
------------

// File: rtl/rv_fdivsqrt.sv
// ---------------------------------------------------------------------------
// rv_fdivsqrt : iterative IEEE-754 divide / square-root unit (zfinx operands)
//
// One operation per start, fixed latency of N+3 cycles, where
// N = ceil((MANW+3)/QPC) is the number of recurrence cycles. Subnormal inputs
// are flushed to signed zero and no subnormal results are produced. Rounding
// is always round-to-nearest-even.
//
// Ports
//   clk     in   1    clock
//   xreset  in   1    asynchronous active-low reset
//   rdy     in   1    pipeline enable; 0 freezes every register
//   start   in   1    launch request, sampled when rdy=1 and idle
//   op      in   1    0: rs1/rs2 (FDIV), 1: sqrt(rs1) (FSQRT)
//   rs1     in   FW   dividend / radicand
//   rs2     in   FW   divisor (ignored for sqrt)
//   busy    out  1    high from the launch edge until the completing edge
//   cmpl    out  1    one-cycle (rdy-qualified) completion pulse
//   result  out  FW   rounded result, held until the next completion
//   fflags  out  5    {NV,DZ,OF,UF,NX}, held with result
// ---------------------------------------------------------------------------
module rv_fdivsqrt #(
   parameter int EXPW   = 8,
   parameter int MANW   = 23,
   parameter int QPC    = 2,
   parameter int SQRTEN = 1
) (
   input  logic               clk,
   input  logic               xreset,
   input  logic               rdy,
   input  logic               start,
   input  logic               op,
   input  logic [EXPW+MANW:0] rs1,
   input  logic [EXPW+MANW:0] rs2,
   output logic               busy,
   output logic               cmpl,
   output logic [EXPW+MANW:0] result,
   output logic [4:0]         fflags
);

   localparam int FW   = 1 + EXPW + MANW;
   localparam int BIAS = (2 ** (EXPW - 1)) - 1;
   localparam int EMAX = (2 ** EXPW) - 1;
   localparam int N    = (MANW + 3 + QPC - 1) / QPC;
   localparam int QB   = N * QPC;          // quotient/root bits produced
   localparam int REMW = QB + 3;           // partial remainder width
   localparam int RADW = 2 * QB;           // radicand shift register width
   localparam int CW   = $clog2(N + 1);
   localparam int XW   = EXPW + 2;         // exponent width incl. sign/overflow

   localparam logic [FW-1:0] QNAN = {1'b0, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PREP  = 2'd1,
      S_ITER  = 2'd2,
      S_ROUND = 2'd3
   } state_t;

   state_t            state_r, state_n;

   logic              op_r;
   logic [FW-1:0]     a_r, b_r;
   logic              busy_r, cmpl_r;
   logic [FW-1:0]     result_r;
   logic [4:0]        fflags_r;
   logic              sign_r;
   logic [XW-1:0]     exp_r;
   logic              spec_r;
   logic [FW-1:0]     spec_res_r;
   logic [4:0]        spec_flg_r;
   logic [REMW-1:0]   rem_r;
   logic [QB-1:0]     q_r;
   logic [RADW-1:0]   rad_r;
   logic [MANW:0]     div_r;
   logic [CW-1:0]     cnt_r;

   assign busy   = busy_r;
   assign cmpl   = cmpl_r;
   assign result = result_r;
   assign fflags = fflags_r;

   // ---------------- operand classification ----------------
   logic              s1_s, s2_s;
   logic [EXPW-1:0]   e1_s, e2_s;
   logic [MANW-1:0]   f1_s, f2_s;
   logic              zero1_s, zero2_s, inf1_s, inf2_s, nan1_s, nan2_s, snan1_s, snan2_s;
   logic              sq_op_s;

   assign s1_s    = a_r[FW-1];
   assign e1_s    = a_r[FW-2:MANW];
   assign f1_s    = a_r[MANW-1:0];
   assign s2_s    = b_r[FW-1];
   assign e2_s    = b_r[FW-2:MANW];
   assign f2_s    = b_r[MANW-1:0];

   // A zero exponent covers both true zeros and flushed subnormals.
   assign zero1_s = (e1_s == {EXPW{1'b0}});
   assign zero2_s = (e2_s == {EXPW{1'b0}});
   assign inf1_s  = (&e1_s) && (f1_s == {MANW{1'b0}});
   assign inf2_s  = (&e2_s) && (f2_s == {MANW{1'b0}});
   assign nan1_s  = (&e1_s) && (f1_s != {MANW{1'b0}});
   assign nan2_s  = (&e2_s) && (f2_s != {MANW{1'b0}});
   assign snan1_s = nan1_s && !f1_s[MANW-1];
   assign snan2_s = nan2_s && !f2_s[MANW-1];

   assign sq_op_s = op_r && (SQRTEN != 0);

   // Special-operand resolution, evaluated in PREP on the latched operands.
   logic              spec_s;
   logic [FW-1:0]     spec_res_s;
   logic [4:0]        spec_flg_s;

   // Special-case priority decoder for div and sqrt.
   always_comb begin
      spec_s     = 1'b1;
      spec_res_s = {FW{1'b0}};
      spec_flg_s = 5'b00000;
      if (op_r) begin
         if (SQRTEN == 0) begin
            spec_res_s = QNAN;
            spec_flg_s = 5'b10000;
         end else if (snan1_s) begin
            spec_res_s = QNAN;
            spec_flg_s = 5'b10000;
         end else if (nan1_s) begin
            spec_res_s = QNAN;
         end else if (s1_s && !zero1_s) begin
            spec_res_s = QNAN;
            spec_flg_s = 5'b10000;
         end else if (zero1_s) begin
            spec_res_s = {s1_s, {(FW-1){1'b0}}};
         end else if (inf1_s) begin
            spec_res_s = {1'b0, {EXPW{1'b1}}, {MANW{1'b0}}};
         end else begin
            spec_s = 1'b0;
         end
      end else begin
         if (snan1_s || snan2_s) begin
            spec_res_s = QNAN;
            spec_flg_s = 5'b10000;
         end else if (nan1_s || nan2_s) begin
            spec_res_s = QNAN;
         end else if ((zero1_s && zero2_s) || (inf1_s && inf2_s)) begin
            spec_res_s = QNAN;
            spec_flg_s = 5'b10000;
         end else if (zero2_s && !inf1_s) begin
            spec_res_s = {s1_s ^ s2_s, {EXPW{1'b1}}, {MANW{1'b0}}};
            spec_flg_s = 5'b01000;
         end else if (inf1_s) begin
            spec_res_s = {s1_s ^ s2_s, {EXPW{1'b1}}, {MANW{1'b0}}};
         end else if (zero1_s || inf2_s) begin
            spec_res_s = {s1_s ^ s2_s, {(FW-1){1'b0}}};
         end else begin
            spec_s = 1'b0;
         end
      end
   end

   // ---------------- exponent / significand setup ----------------
   logic [XW-1:0]     dexp_s, uexp_s, sexp_s;
   logic [MANW+1:0]   sq_sig_s;

   assign dexp_s   = {2'b00, e1_s} - {2'b00, e2_s} + XW'(BIAS);
   assign uexp_s   = {2'b00, e1_s} - XW'(BIAS);
   // Arithmetic halving of the unbiased exponent (floor for odd negatives).
   assign sexp_s   = {uexp_s[XW-1], uexp_s[XW-1:1]} + XW'(BIAS);
   // Odd unbiased exponent: radicand doubled, value kept with 2 integer bits.
   assign sq_sig_s = uexp_s[0] ? {1'b1, f1_s, 1'b0} : {2'b01, f1_s};

   // ---------------- digit recurrence ----------------
   logic [REMW-1:0]   rem_n, trial_s;
   logic [QB-1:0]     q_n;
   logic [RADW-1:0]   rad_n;

   // QPC restoring steps per cycle: divide compares then shifts; sqrt
   // brings in two radicand bits then compares against 4*root+1.
   always_comb begin
      rem_n   = rem_r;
      q_n     = q_r;
      rad_n   = rad_r;
      trial_s = {REMW{1'b0}};
      for (int k = 0; k < QPC; k++) begin
         if (sq_op_s) begin
            rem_n   = {rem_n[REMW-3:0], rad_n[RADW-1 -: 2]};
            rad_n   = {rad_n[RADW-3:0], 2'b00};
            trial_s = REMW'({q_n, 2'b01});
         end else begin
            trial_s = REMW'(div_r);
         end
         if (rem_n >= trial_s) begin
            rem_n = rem_n - trial_s;
            q_n   = {q_n[QB-2:0], 1'b1};
         end else begin
            q_n   = {q_n[QB-2:0], 1'b0};
         end
         rem_n = sq_op_s ? rem_n : {rem_n[REMW-2:0], 1'b0};
      end
   end

   // ---------------- normalise and round ----------------
   logic [QB-1:0]     nq_s;
   logic [XW-1:0]     nexp_s, fexp_s;
   logic [MANW:0]     man_s;
   logic              guard_s, sticky_s, up_s, carry_s, ovf_s, unf_s;
   logic [MANW+1:0]   rsig_s;
   logic [MANW-1:0]   fman_s;
   logic [FW-1:0]     fin_res_s;
   logic [4:0]        fin_flg_s;

   // Only a quotient in [0.5,1) can have a clear MSB; sqrt roots are in [1,2).
   assign nq_s     = q_r[QB-1] ? q_r : {q_r[QB-2:0], 1'b0};
   assign nexp_s   = q_r[QB-1] ? exp_r : (exp_r - XW'(1));
   assign man_s    = nq_s[QB-1 -: MANW+1];
   assign guard_s  = nq_s[QB-2-MANW];
   assign sticky_s = (|nq_s[QB-3-MANW:0]) || (rem_r != {REMW{1'b0}});
   assign up_s     = guard_s && (sticky_s || man_s[0]);
   assign rsig_s   = {1'b0, man_s} + (MANW+2)'(up_s);
   assign carry_s  = rsig_s[MANW+1];
   assign fexp_s   = nexp_s + XW'(carry_s);
   assign fman_s   = carry_s ? {MANW{1'b0}} : rsig_s[MANW-1:0];
   assign ovf_s    = !fexp_s[XW-1] && (fexp_s >= XW'(EMAX));
   assign unf_s    = fexp_s[XW-1] || (fexp_s == {XW{1'b0}});

   // Final result select: specials, overflow, underflow, or normal number.
   always_comb begin
      fin_res_s = {FW{1'b0}};
      fin_flg_s = 5'b00000;
      if (spec_r) begin
         fin_res_s = spec_res_r;
         fin_flg_s = spec_flg_r;
      end else if (ovf_s) begin
         fin_res_s = {sign_r, {EXPW{1'b1}}, {MANW{1'b0}}};
         fin_flg_s = 5'b00101;
      end else if (unf_s) begin
         fin_res_s = {sign_r, {(FW-1){1'b0}}};
         fin_flg_s = 5'b00011;
      end else begin
         fin_res_s = {sign_r, fexp_s[EXPW-1:0], fman_s};
         fin_flg_s = {4'b0000, guard_s || sticky_s};
      end
   end

   // ---------------- control ----------------
   // Next-state logic for the IDLE/PREP/ITER/ROUND sequence.
   always_comb begin
      state_n = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_n = S_PREP;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_PREP: state_n = S_ITER;
         S_ITER: begin
            if (cnt_r == {CW{1'b0}}) begin
               state_n = S_ROUND;
            end else begin
               state_n = S_ITER;
            end
         end
         S_ROUND: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // State register, frozen while rdy is low.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         state_r <= S_IDLE;
      end else if (rdy) begin
         state_r <= state_n;
      end else begin
         state_r <= state_r;
      end
   end

   // Operand latch, datapath and registered outputs, frozen while rdy is low.
   always_ff @(posedge clk or negedge xreset) begin
      if (!xreset) begin
         op_r       <= 1'b0;
         a_r        <= {FW{1'b0}};
         b_r        <= {FW{1'b0}};
         busy_r     <= 1'b0;
         cmpl_r     <= 1'b0;
         result_r   <= {FW{1'b0}};
         fflags_r   <= 5'b00000;
         sign_r     <= 1'b0;
         exp_r      <= {XW{1'b0}};
         spec_r     <= 1'b0;
         spec_res_r <= {FW{1'b0}};
         spec_flg_r <= 5'b00000;
         rem_r      <= {REMW{1'b0}};
         q_r        <= {QB{1'b0}};
         rad_r      <= {RADW{1'b0}};
         div_r      <= {(MANW+1){1'b0}};
         cnt_r      <= {CW{1'b0}};
      end else if (rdy) begin
         case (state_r)
            S_IDLE: begin
               cmpl_r <= 1'b0;
               if (start) begin
                  op_r   <= op;
                  a_r    <= rs1;
                  b_r    <= rs2;
                  busy_r <= 1'b1;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            S_PREP: begin
               spec_r     <= spec_s;
               spec_res_r <= spec_res_s;
               spec_flg_r <= spec_flg_s;
               sign_r     <= op_r ? s1_s : (s1_s ^ s2_s);
               exp_r      <= op_r ? sexp_s : dexp_s;
               q_r        <= {QB{1'b0}};
               div_r      <= {1'b1, f2_s};
               rad_r      <= {sq_sig_s, {(RADW-MANW-2){1'b0}}};
               rem_r      <= sq_op_s ? {REMW{1'b0}} : REMW'({1'b1, f1_s});
               cnt_r      <= CW'(N - 1);
            end
            S_ITER: begin
               rem_r <= rem_n;
               q_r   <= q_n;
               rad_r <= rad_n;
               cnt_r <= (cnt_r == {CW{1'b0}}) ? cnt_r : (cnt_r - CW'(1));
            end
            S_ROUND: begin
               result_r <= fin_res_s;
               fflags_r <= fin_flg_s;
               cmpl_r   <= 1'b1;
               busy_r   <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end else begin
         cmpl_r <= cmpl_r;
      end
   end

endmodule

// File: tb/tb_rv_fdivsqrt.sv
// ---------------------------------------------------------------------------
// tb_rv_fdivsqrt : directed self-checking bench for rv_fdivsqrt.
// Three builds (QPC=2,1,4) share the stimulus; each is checked for result,
// flags and latency against hand-computed binary32 values.
// ---------------------------------------------------------------------------
module tb_rv_fdivsqrt;

   logic        clk = 1'b0;
   logic        xreset, rdy, start, op;
   logic [31:0] rs1, rs2;
   logic        busy2, cmpl2, busy1, cmpl1, busy4, cmpl4;
   logic [31:0] res2, res1, res4;
   logic [4:0]  flg2, flg1, flg4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_fdivsqrt #(.EXPW(8), .MANW(23), .QPC(2), .SQRTEN(1)) dut (
      .clk(clk), .xreset(xreset), .rdy(rdy), .start(start), .op(op),
      .rs1(rs1), .rs2(rs2), .busy(busy2), .cmpl(cmpl2), .result(res2), .fflags(flg2));

   rv_fdivsqrt #(.EXPW(8), .MANW(23), .QPC(1), .SQRTEN(1)) dut_q1 (
      .clk(clk), .xreset(xreset), .rdy(rdy), .start(start), .op(op),
      .rs1(rs1), .rs2(rs2), .busy(busy1), .cmpl(cmpl1), .result(res1), .fflags(flg1));

   rv_fdivsqrt #(.EXPW(8), .MANW(23), .QPC(4), .SQRTEN(1)) dut_q4 (
      .clk(clk), .xreset(xreset), .rdy(rdy), .start(start), .op(op),
      .rs1(rs1), .rs2(rs2), .busy(busy4), .cmpl(cmpl4), .result(res4), .fflags(flg4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Launch one op, optionally stall rdy for 5 cycles from iteration 'stall'
   // and/or pulse a second start while busy, then check all three builds.
   task automatic run_op(input string tag, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er,
                         input logic [4:0] ef, input int stall, input bit poke);
      int lat2, lat1, lat4, busyc, extra;
      logic [31:0] r2, r1, r4;
      logic [4:0]  f2, f1, f4;
      lat2 = -1; lat1 = -1; lat4 = -1; busyc = 0;
      r2 = '0; r1 = '0; r4 = '0; f2 = '0; f1 = '0; f4 = '0;
      extra = (stall > 0) ? 5 : 0;
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      tick;
      start = 1'b0; rs1 = 32'h5A5A5A5A; rs2 = 32'hA5A5A5A5; op = ~o;
      for (int i = 1; i <= 60; i++) begin
         if (lat2 < 0 && busy2 === 1'b1) busyc++;
         if (stall > 0 && i == stall) rdy = 1'b0;
         if (stall > 0 && i == stall + 5) rdy = 1'b1;
         if (poke && i == 5) begin
            start = 1'b1; op = 1'b0; rs1 = 32'h3F800000; rs2 = 32'h3F800000;
         end
         if (poke && i == 6) start = 1'b0;
         tick;
         if (lat2 < 0 && cmpl2 === 1'b1) begin lat2 = i; r2 = res2; f2 = flg2; end
         if (lat1 < 0 && cmpl1 === 1'b1) begin lat1 = i; r1 = res1; f1 = flg1; end
         if (lat4 < 0 && cmpl4 === 1'b1) begin lat4 = i; r4 = res4; f4 = flg4; end
         if (lat2 >= 0 && lat1 >= 0 && lat4 >= 0) break;
      end
      rdy = 1'b1; start = 1'b0;
      chk({tag, ".res"},    r2, er);
      chk({tag, ".flags"},  32'(f2), 32'(ef));
      chk({tag, ".lat"},    lat2, 15 + extra);
      chk({tag, ".busy"},   busyc, 15 + extra);
      chk({tag, ".q1res"},  r1, er);
      chk({tag, ".q1flg"},  32'(f1), 32'(ef));
      chk({tag, ".q1lat"},  lat1, 28 + extra);
      chk({tag, ".q4res"},  r4, er);
      chk({tag, ".q4flg"},  32'(f4), 32'(ef));
      chk({tag, ".q4lat"},  lat4, 9 + extra);
   endtask

   initial begin
      logic seen;
      xreset = 1'b0; rdy = 1'b1; start = 1'b0; op = 1'b0; rs1 = '0; rs2 = '0;
      tick; tick; tick;
      chk("rst.busy",   32'(busy2), 32'd0);
      chk("rst.cmpl",   32'(cmpl2), 32'd0);
      chk("rst.result", res2, 32'h00000000);
      chk("rst.fflags", 32'(flg2), 32'd0);
      xreset = 1'b1;
      tick;

      run_op("div6_2",    1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 0, 1'b0);
      run_op("div1_3",    1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 0, 1'b0);
      run_op("sqrt2",     1'b1, 32'h40000000, 32'h00000000, 32'h3FB504F3, 5'b00001, 0, 1'b0);
      run_op("div1_0",    1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 0, 1'b0);
      run_op("divm1_0",   1'b0, 32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 0, 1'b0);
      run_op("sqrtm4",    1'b1, 32'hC0800000, 32'h00000000, 32'h7FC00000, 5'b10000, 0, 1'b0);
      run_op("div_ovf",   1'b0, 32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 0, 1'b0);
      run_op("div_unf",   1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 0, 1'b0);
      run_op("sqrt4",     1'b1, 32'h40800000, 32'h00000000, 32'h40000000, 5'b00000, 0, 1'b0);
      run_op("sqrt9_pk",  1'b1, 32'h41100000, 32'h00000000, 32'h40400000, 5'b00000, 0, 1'b1);
      run_op("sqrt1",     1'b1, 32'h3F800000, 32'h00000000, 32'h3F800000, 5'b00000, 0, 1'b0);
      run_op("div1_1p5",  1'b0, 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAB, 5'b00001, 0, 1'b0);
      run_op("divm6_2",   1'b0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 0, 1'b0);
      run_op("div_qnan",  1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000, 0, 1'b0);
      run_op("div_snan",  1'b0, 32'h3F800000, 32'h7F800001, 32'h7FC00000, 5'b10000, 0, 1'b0);
      run_op("div0_0",    1'b0, 32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000, 0, 1'b0);
      run_op("divinf",    1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000, 0, 1'b0);
      run_op("divminf_2", 1'b0, 32'hFF800000, 32'h40000000, 32'hFF800000, 5'b00000, 0, 1'b0);
      run_op("divm1_inf", 1'b0, 32'hBF800000, 32'h7F800000, 32'h80000000, 5'b00000, 0, 1'b0);
      run_op("sqrtm0",    1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000, 0, 1'b0);
      run_op("sqrtinf",   1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 0, 1'b0);
      run_op("div_sub",   1'b0, 32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 0, 1'b0);
      run_op("div_two",   1'b0, 32'h3FFFFFFF, 32'h3F7FFFFF, 32'h40000000, 5'b00000, 0, 1'b0);
      run_op("stall",     1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 4, 1'b0);

      // Abort an op mid-recurrence with a reset pulse.
      op = 1'b0; rs1 = 32'h40C00000; rs2 = 32'h40000000; start = 1'b1;
      tick;
      start = 1'b0;
      repeat (6) tick;
      xreset = 1'b0;
      #1;
      chk("abort.busy",   32'(busy2), 32'd0);
      chk("abort.cmpl",   32'(cmpl2), 32'd0);
      chk("abort.result", res2, 32'h00000000);
      chk("abort.fflags", 32'(flg2), 32'd0);
      chk("abort.q1res",  res1, 32'h00000000);
      tick; tick;
      xreset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         tick;
         if (cmpl2 === 1'b1 || cmpl1 === 1'b1 || cmpl4 === 1'b1) seen = 1'b1;
      end
      chk("abort.nocmpl", 32'(seen), 32'd0);
      run_op("after_rst", 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
